// File: rtl/fpnew_rounding_lanes_snax_pkg.sv
// -----------------------------------------------------------------------------
// fpnew_pkg_snax
// Shared types for the SNAX FP rounding datapath.
//   roundmode_e        RISC-V rounding-mode encoding (3 bits)
//   lane_flags_t       per-lane status {exact_zero, inexact, carry_out}
//   is_valid_rnd_mode  1 for RNE/RTZ/RDN/RUP/RMM, 0 for the remaining codes
// -----------------------------------------------------------------------------
package fpnew_pkg_snax;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic exact_zero;
    logic inexact;
    logic carry_out;
  } lane_flags_t;

  function automatic logic is_valid_rnd_mode(input roundmode_e mode);
    return (mode inside {RNE, RTZ, RDN, RUP, RMM});
  endfunction

endpackage

// File: rtl/fpnew_round_lane_snax.sv
// -----------------------------------------------------------------------------
// fpnew_round_lane_snax
// Purely combinational rounding of one lane.
//   abs_value_i              pre-normalised magnitude
//   sign_i                   lane sign
//   round_sticky_bits_i      {R,S}
//   rnd_mode_i               rounding mode; unsupported codes truncate
//   effective_subtraction_i  selects the sign of an exact-zero result
//   lane_mask_i              0 forces every output of the lane to zero
//   abs_rounded_o            magnitude after the increment, truncated
//   sign_o                   result sign
//   flags_o                  {exact_zero, inexact, carry_out}
// -----------------------------------------------------------------------------
module fpnew_round_lane_snax
  import fpnew_pkg_snax::*;
#(
  parameter int unsigned AbsWidth = 8
) (
  input  logic [AbsWidth-1:0] abs_value_i,
  input  logic                sign_i,
  input  logic [1:0]          round_sticky_bits_i,
  input  roundmode_e          rnd_mode_i,
  input  logic                effective_subtraction_i,
  input  logic                lane_mask_i,
  output logic [AbsWidth-1:0] abs_rounded_o,
  output logic                sign_o,
  output lane_flags_t         flags_o
);

  logic              w_round_up;
  logic              w_any_rs;
  logic              w_exact_zero;
  logic [AbsWidth:0] w_sum;

  assign w_any_rs = |round_sticky_bits_i;

  // NOTE: every variable of an always_comb gets a default before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_round_up = 1'b0;
    case (rnd_mode_i)
      RNE: begin
        case (round_sticky_bits_i)
          2'b10:   w_round_up = abs_value_i[0];  // tie: round to even
          2'b11:   w_round_up = 1'b1;
          default: w_round_up = 1'b0;
        endcase
      end
      RTZ:     w_round_up = 1'b0;
      RDN:     w_round_up = w_any_rs & sign_i;
      RUP:     w_round_up = w_any_rs & ~sign_i;
      RMM:     w_round_up = round_sticky_bits_i[1];
      default: w_round_up = 1'b0;  // unsupported codes behave as RTZ
    endcase
  end

  // One extra bit catches the overflow of an all-ones magnitude.
  assign w_sum        = {1'b0, abs_value_i} + {{AbsWidth{1'b0}}, w_round_up};
  assign w_exact_zero = (abs_value_i == '0) && (round_sticky_bits_i == 2'b00);

  always_comb begin
    abs_rounded_o = '0;
    sign_o        = 1'b0;
    flags_o       = '0;
    if (lane_mask_i) begin
      abs_rounded_o      = w_sum[AbsWidth-1:0];
      // x - x is +0 in every mode except round-down, where it is -0.
      sign_o             = (w_exact_zero && effective_subtraction_i) ?
                           (rnd_mode_i == RDN) : sign_i;
      flags_o.exact_zero = w_exact_zero;
      flags_o.inexact    = w_any_rs;
      flags_o.carry_out  = w_sum[AbsWidth];
    end
  end

endmodule

// File: rtl/fpnew_rounding_lanes_snax.sv
// -----------------------------------------------------------------------------
// fpnew_rounding_lanes_snax
// NumLanes rounding lanes sharing one rounding mode, followed by NumPipeRegs
// ready-chained register stages and a sticky inexact accumulator.
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_i                   drops every in-flight entry at the next edge
//   in_valid_i / in_ready_o   input handshake
//   abs_value_i, sign_i, round_sticky_bits_i, effective_subtraction_i,
//   lane_mask_i               per-lane operands, lane 0 in the LSBs
//   rnd_mode_i                rounding mode for all lanes
//   tag_i / tag_o             opaque tag travelling with the entry
//   out_valid_o / out_ready_i output handshake
//   abs_rounded_o, sign_o, exact_zero_o, inexact_o, carry_out_o
//                             per-lane results
//   invalid_mode_o            rnd_mode was not a supported code
//   busy_o                    some stage holds a valid entry
//   acc_clear_i / acc_inexact_o  sticky OR of inexact over output handshakes
// -----------------------------------------------------------------------------
module fpnew_rounding_lanes_snax
  import fpnew_pkg_snax::*;
#(
  parameter int unsigned AbsWidth    = 8,
  parameter int unsigned NumLanes    = 4,
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned TagWidth    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NumLanes*AbsWidth-1:0] abs_value_i,
  input  logic [NumLanes-1:0]          sign_i,
  input  logic [2*NumLanes-1:0]        round_sticky_bits_i,
  input  roundmode_e                   rnd_mode_i,
  input  logic [NumLanes-1:0]          effective_subtraction_i,
  input  logic [NumLanes-1:0]          lane_mask_i,
  input  logic [TagWidth-1:0]          tag_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [NumLanes*AbsWidth-1:0] abs_rounded_o,
  output logic [NumLanes-1:0]          sign_o,
  output logic [NumLanes-1:0]          exact_zero_o,
  output logic [NumLanes-1:0]          inexact_o,
  output logic [NumLanes-1:0]          carry_out_o,
  output logic                         invalid_mode_o,
  output logic [TagWidth-1:0]          tag_o,
  output logic                         busy_o,
  input  logic                         acc_clear_i,
  output logic                         acc_inexact_o
);

  localparam int unsigned LaneBits = NumLanes * AbsWidth;
  localparam int unsigned DataW    = LaneBits + 4 * NumLanes + 1 + TagWidth;

  logic [LaneBits-1:0] w_abs_rounded;
  logic [NumLanes-1:0] w_sign;
  logic [NumLanes-1:0] w_exact_zero;
  logic [NumLanes-1:0] w_inexact;
  logic [NumLanes-1:0] w_carry_out;
  lane_flags_t         w_flags [NumLanes];
  logic [DataW-1:0]    w_in_data;
  logic [DataW-1:0]    w_out_data;
  logic                r_acc_inexact;

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    fpnew_round_lane_snax #(
      .AbsWidth(AbsWidth)
    ) u_lane (
      .abs_value_i            (abs_value_i[l*AbsWidth +: AbsWidth]),
      .sign_i                 (sign_i[l]),
      .round_sticky_bits_i    (round_sticky_bits_i[2*l +: 2]),
      .rnd_mode_i             (rnd_mode_i),
      .effective_subtraction_i(effective_subtraction_i[l]),
      .lane_mask_i            (lane_mask_i[l]),
      .abs_rounded_o          (w_abs_rounded[l*AbsWidth +: AbsWidth]),
      .sign_o                 (w_sign[l]),
      .flags_o                (w_flags[l])
    );
    assign w_exact_zero[l] = w_flags[l].exact_zero;
    assign w_inexact[l]    = w_flags[l].inexact;
    assign w_carry_out[l]  = w_flags[l].carry_out;
  end

  assign w_in_data = {tag_i, ~is_valid_rnd_mode(rnd_mode_i), w_carry_out,
                      w_inexact, w_exact_zero, w_sign, w_abs_rounded};

  if (NumPipeRegs == 0) begin : g_bypass
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i;
    assign w_out_data  = w_in_data;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic [NumPipeRegs-1:0] r_valid;
    logic [DataW-1:0]       r_data [NumPipeRegs];
    // Index s is what stage s would load; index NumPipeRegs is the consumer.
    logic [NumPipeRegs:0]   w_ready;
    logic [NumPipeRegs:0]   w_valid_chain;
    logic [DataW-1:0]       w_data_chain [NumPipeRegs+1];

    always_comb begin
      w_ready              = '0;
      w_valid_chain        = '0;
      w_ready[NumPipeRegs] = out_ready_i;
      w_valid_chain[0]     = in_valid_i;
      w_data_chain[0]      = w_in_data;
      for (int s = 0; s < NumPipeRegs; s++) begin
        w_valid_chain[s+1] = r_valid[s];
        w_data_chain[s+1]  = r_data[s];
      end
      // A full stage still accepts when its own entry moves on this cycle.
      for (int s = int'(NumPipeRegs) - 1; s >= 0; s--) begin
        w_ready[s] = ~r_valid[s] | w_ready[s+1];
      end
    end

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its upstream neighbour's pre-edge value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_valid <= '0;
        // NOTE: the data registers are reset as well because the outputs
        // must read zero during reset, not only be marked invalid.
        for (int s = 0; s < NumPipeRegs; s++) begin
          r_data[s] <= '0;
        end
      end else if (flush_i) begin
        r_valid <= '0;
      end else begin
        for (int s = 0; s < NumPipeRegs; s++) begin
          if (w_ready[s]) begin
            r_valid[s] <= w_valid_chain[s];
            if (w_valid_chain[s]) begin
              r_data[s] <= w_data_chain[s];
            end
          end
        end
      end
    end

    assign in_ready_o  = w_ready[0];
    assign out_valid_o = r_valid[NumPipeRegs-1];
    assign w_out_data  = r_data[NumPipeRegs-1];
    assign busy_o      = |r_valid;
  end

  assign {tag_o, invalid_mode_o, carry_out_o, inexact_o, exact_zero_o,
          sign_o, abs_rounded_o} = w_out_data;

  // Set has priority so an inexact result retiring with a clear is not lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_inexact <= 1'b0;
    end else if (out_valid_o && out_ready_i && (|inexact_o)) begin
      r_acc_inexact <= 1'b1;
    end else if (acc_clear_i) begin
      r_acc_inexact <= 1'b0;
    end
  end

  assign acc_inexact_o = r_acc_inexact;

endmodule

// File: tb/tb_fpnew_rounding_lanes_snax.sv
module tb_fpnew_rounding_lanes_snax;
  import fpnew_pkg_snax::*;

  localparam int unsigned AW = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned TW = 4;

  logic             clk_i;
  logic             rst_ni;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [NL*AW-1:0] abs_value_i;
  logic [NL-1:0]    sign_i;
  logic [2*NL-1:0]  round_sticky_bits_i;
  roundmode_e       rnd_mode_i;
  logic [NL-1:0]    effective_subtraction_i;
  logic [NL-1:0]    lane_mask_i;
  logic [TW-1:0]    tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [NL*AW-1:0] abs_rounded_o;
  logic [NL-1:0]    sign_o;
  logic [NL-1:0]    exact_zero_o;
  logic [NL-1:0]    inexact_o;
  logic [NL-1:0]    carry_out_o;
  logic             invalid_mode_o;
  logic [TW-1:0]    tag_o;
  logic             busy_o;
  logic             acc_clear_i;
  logic             acc_inexact_o;

  int n_cmp = 0;
  int n_mis = 0;

  fpnew_rounding_lanes_snax #(
    .AbsWidth(AW), .NumLanes(NL), .NumPipeRegs(NP), .TagWidth(TW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .abs_value_i(abs_value_i), .sign_i(sign_i),
    .round_sticky_bits_i(round_sticky_bits_i), .rnd_mode_i(rnd_mode_i),
    .effective_subtraction_i(effective_subtraction_i),
    .lane_mask_i(lane_mask_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .abs_rounded_o(abs_rounded_o), .sign_o(sign_o),
    .exact_zero_o(exact_zero_o), .inexact_o(inexact_o),
    .carry_out_o(carry_out_o), .invalid_mode_o(invalid_mode_o),
    .tag_o(tag_o), .busy_o(busy_o),
    .acc_clear_i(acc_clear_i), .acc_inexact_o(acc_inexact_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed vectors for lanes 0 and 1; lanes 2 and 3 stay masked with
  // noisy operands. Two-bit expectations are {lane1, lane0}.
  typedef struct {
    roundmode_e  mode;
    logic [7:0]  a0; logic s0; logic [1:0] rs0; logic es0;
    logic [7:0]  a1; logic s1; logic [1:0] rs1; logic es1;
    logic [15:0] exp_abs;
    logic [1:0]  exp_sign, exp_ez, exp_inx, exp_co;
    logic        exp_inv;
  } vec_t;

  vec_t vecs [12] = '{
    '{RNE, 8'h04,1'b0,2'b10,1'b0, 8'h05,1'b0,2'b10,1'b0, 16'h0604, 2'b00,2'b00,2'b11,2'b00, 1'b0},
    '{RNE, 8'hFF,1'b0,2'b11,1'b0, 8'h80,1'b0,2'b01,1'b0, 16'h8000, 2'b00,2'b00,2'b11,2'b01, 1'b0},
    '{RUP, 8'h10,1'b1,2'b01,1'b0, 8'h10,1'b0,2'b01,1'b0, 16'h1110, 2'b01,2'b00,2'b11,2'b00, 1'b0},
    '{RMM, 8'h07,1'b0,2'b10,1'b0, 8'h07,1'b0,2'b01,1'b0, 16'h0708, 2'b00,2'b00,2'b11,2'b00, 1'b0},
    '{RDN, 8'h07,1'b1,2'b01,1'b0, 8'h07,1'b0,2'b11,1'b0, 16'h0708, 2'b01,2'b00,2'b11,2'b00, 1'b0},
    '{RTZ, 8'h07,1'b0,2'b11,1'b0, 8'hFF,1'b0,2'b11,1'b0, 16'hFF07, 2'b00,2'b00,2'b11,2'b00, 1'b0},
    '{RNE, 8'h03,1'b0,2'b10,1'b0, 8'h03,1'b0,2'b01,1'b0, 16'h0304, 2'b00,2'b00,2'b11,2'b00, 1'b0},
    '{RDN, 8'h00,1'b0,2'b00,1'b1, 8'h00,1'b1,2'b00,1'b0, 16'h0000, 2'b11,2'b11,2'b00,2'b00, 1'b0},
    '{RNE, 8'h00,1'b1,2'b00,1'b1, 8'h00,1'b0,2'b01,1'b1, 16'h0000, 2'b00,2'b01,2'b10,2'b00, 1'b0},
    '{roundmode_e'(3'b110), 8'h05,1'b0,2'b11,1'b0, 8'hFF,1'b0,2'b11,1'b0, 16'hFF05, 2'b00,2'b00,2'b11,2'b00, 1'b1},
    '{roundmode_e'(3'b111), 8'hFF,1'b0,2'b11,1'b0, 8'h00,1'b0,2'b00,1'b1, 16'h00FF, 2'b00,2'b10,2'b01,2'b00, 1'b1},
    '{RUP, 8'hFF,1'b0,2'b01,1'b0, 8'hFE,1'b1,2'b01,1'b0, 16'hFE00, 2'b10,2'b00,2'b11,2'b01, 1'b0}
  };

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [7:0] a, input logic s,
                          input logic [1:0] rs, input logic es, input logic m);
    abs_value_i[l*8 +: 8]             = a;
    sign_i[l]                         = s;
    round_sticky_bits_i[l*2 +: 2]     = rs;
    effective_subtraction_i[l]        = es;
    lane_mask_i[l]                    = m;
  endtask

  task automatic park_lanes();
    for (int l = 0; l < 4; l++) set_lane(l, 8'hAA, 1'b1, 2'b11, 1'b1, 1'b0);
  endtask

  // Offers one entry (pipeline assumed able to accept) and waits for it.
  task automatic push_and_wait(output int lat);
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    lat = 1;
    while (out_valid_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL reset out_valid: got %b want 0", out_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset busy: got %b want 0", busy_o); end
    n_cmp++; if (acc_inexact_o !== 1'b0) begin n_mis++; $display("FAIL reset acc: got %b want 0", acc_inexact_o); end
    n_cmp++; if (abs_rounded_o !== 32'h0) begin n_mis++; $display("FAIL reset abs: got %h want 0", abs_rounded_o); end
    n_cmp++; if ({tag_o, sign_o, inexact_o, carry_out_o, exact_zero_o, invalid_mode_o} !== '0) begin
      n_mis++; $display("FAIL reset flags/tag: got %h want 0",
                        {tag_o, sign_o, inexact_o, carry_out_o, exact_zero_o, invalid_mode_o});
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_rounding_vectors();
    int lat;
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      park_lanes();
      set_lane(0, vecs[i].a0, vecs[i].s0, vecs[i].rs0, vecs[i].es0, 1'b1);
      set_lane(1, vecs[i].a1, vecs[i].s1, vecs[i].rs1, vecs[i].es1, 1'b1);
      rnd_mode_i = vecs[i].mode;
      tag_i      = 4'(i);
      #1;
      n_cmp++; if (in_ready_o !== 1'b1) begin n_mis++; $display("FAIL vec%0d in_ready: got %b want 1", i, in_ready_o); end
      push_and_wait(lat);
      n_cmp++; if (lat != 2) begin n_mis++; $display("FAIL vec%0d latency: got %0d want 2", i, lat); end
      n_cmp++; if (abs_rounded_o !== {16'h0, vecs[i].exp_abs}) begin
        n_mis++; $display("FAIL vec%0d abs: got %h want %h", i, abs_rounded_o, {16'h0, vecs[i].exp_abs}); end
      n_cmp++; if (sign_o !== {2'b00, vecs[i].exp_sign}) begin
        n_mis++; $display("FAIL vec%0d sign: got %b want %b", i, sign_o, {2'b00, vecs[i].exp_sign}); end
      n_cmp++; if (exact_zero_o !== {2'b00, vecs[i].exp_ez}) begin
        n_mis++; $display("FAIL vec%0d exact_zero: got %b want %b", i, exact_zero_o, {2'b00, vecs[i].exp_ez}); end
      n_cmp++; if (inexact_o !== {2'b00, vecs[i].exp_inx}) begin
        n_mis++; $display("FAIL vec%0d inexact: got %b want %b", i, inexact_o, {2'b00, vecs[i].exp_inx}); end
      n_cmp++; if (carry_out_o !== {2'b00, vecs[i].exp_co}) begin
        n_mis++; $display("FAIL vec%0d carry: got %b want %b", i, carry_out_o, {2'b00, vecs[i].exp_co}); end
      n_cmp++; if (invalid_mode_o !== vecs[i].exp_inv) begin
        n_mis++; $display("FAIL vec%0d invalid_mode: got %b want %b", i, invalid_mode_o, vecs[i].exp_inv); end
      n_cmp++; if (tag_o !== 4'(i)) begin n_mis++; $display("FAIL vec%0d tag: got %h want %h", i, tag_o, 4'(i)); end
      step();
    end
    n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL vectors drained: out_valid %b want 0", out_valid_o); end
    n_cmp++; if (acc_inexact_o !== 1'b1) begin n_mis++; $display("FAIL vectors acc: got %b want 1", acc_inexact_o); end
  endtask

  task automatic test_back_to_back();
    int next_tag = 1;
    int exp_tag  = 1;
    int accepted = 0;
    logic hs;
    park_lanes();
    rnd_mode_i  = RTZ;
    out_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 8'(next_tag), 1'b0, 2'b00, 1'b0, 1'b1);
      tag_i      = 4'(next_tag);
      in_valid_i = 1'b1;
      #1;
      hs = in_ready_o;
      if (c >= 2) begin
        n_cmp++; if ({out_valid_o, tag_o, abs_rounded_o} !== {1'b1, 4'h1, 32'h1}) begin
          n_mis++; $display("FAIL stall%0d hold: got v=%b tag=%h abs=%h want v=1 tag=1 abs=1",
                            c, out_valid_o, tag_o, abs_rounded_o);
        end
      end
      step();
      if (hs) begin accepted++; next_tag++; end
    end
    n_cmp++; if (accepted != 2) begin n_mis++; $display("FAIL stall accepts: got %0d want 2", accepted); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_mis++; $display("FAIL stall in_ready: got %b want 0", in_ready_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL stall busy: got %b want 1", busy_o); end

    out_ready_i = 1'b1;
    for (int c = 0; c < 40 && exp_tag <= 6; c++) begin
      in_valid_i = (next_tag <= 6);
      tag_i      = 4'(next_tag);
      set_lane(0, 8'(next_tag), 1'b0, 2'b00, 1'b0, 1'b1);
      #1;
      hs = in_valid_i & in_ready_o;
      if (out_valid_o === 1'b1) begin
        n_cmp++; if (tag_o !== 4'(exp_tag) || abs_rounded_o !== 32'(exp_tag)) begin
          n_mis++; $display("FAIL stream order: got tag=%h abs=%h want tag=%h abs=%h",
                            tag_o, abs_rounded_o, 4'(exp_tag), 32'(exp_tag));
        end
        exp_tag++;
      end
      step();
      if (hs) next_tag++;
    end
    in_valid_i = 1'b0;
    n_cmp++; if (exp_tag != 7) begin n_mis++; $display("FAIL stream count: got %0d outputs want 6", exp_tag - 1); end
    step();
  endtask

  task automatic test_flush();
    park_lanes();
    set_lane(0, 8'h41, 1'b0, 2'b11, 1'b0, 1'b1);
    rnd_mode_i  = RNE;
    out_ready_i = 1'b0;
    n_cmp++; if (acc_inexact_o !== 1'b1) begin n_mis++; $display("FAIL flush pre acc: got %b want 1", acc_inexact_o); end
    in_valid_i = 1'b1; tag_i = 4'h3; step();
    tag_i = 4'h4; step();
    n_cmp++; if ({out_valid_o, busy_o, tag_o} !== {1'b1, 1'b1, 4'h3}) begin
      n_mis++; $display("FAIL flush pre state: got v=%b busy=%b tag=%h want 1 1 3", out_valid_o, busy_o, tag_o); end
    flush_i = 1'b1; tag_i = 4'h5; step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL flush out_valid: got %b want 0", out_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL flush busy: got %b want 0", busy_o); end
    n_cmp++; if (acc_inexact_o !== 1'b1) begin n_mis++; $display("FAIL flush acc: got %b want 1", acc_inexact_o); end
    out_ready_i = 1'b1;
    step(); step(); step();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_mis++; $display("FAIL flush dropped input: out_valid %b want 0", out_valid_o); end
  endtask

  task automatic test_async_reset();
    park_lanes();
    set_lane(0, 8'h41, 1'b0, 2'b11, 1'b0, 1'b1);
    rnd_mode_i  = RNE;
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; tag_i = 4'h9; step();
    tag_i = 4'hA; step();
    in_valid_i = 1'b0;
    n_cmp++; if ({out_valid_o, tag_o, abs_rounded_o} !== {1'b1, 4'h9, 32'h42}) begin
      n_mis++; $display("FAIL areset pre: got v=%b tag=%h abs=%h want 1 9 42", out_valid_o, tag_o, abs_rounded_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if ({out_valid_o, busy_o, acc_inexact_o} !== 3'b000) begin
      n_mis++; $display("FAIL areset ctrl: got v=%b busy=%b acc=%b want 000", out_valid_o, busy_o, acc_inexact_o); end
    n_cmp++; if ({tag_o, abs_rounded_o, sign_o, inexact_o, exact_zero_o, carry_out_o, invalid_mode_o} !== '0) begin
      n_mis++; $display("FAIL areset data: got tag=%h abs=%h inexact=%b want 0", tag_o, abs_rounded_o, inexact_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    step();
  endtask

  task automatic test_accumulator();
    int lat;
    acc_clear_i = 1'b1; step(); acc_clear_i = 1'b0;
    n_cmp++; if (acc_inexact_o !== 1'b0) begin n_mis++; $display("FAIL acc clear0: got %b want 0", acc_inexact_o); end
    park_lanes();
    set_lane(0, 8'h41, 1'b0, 2'b11, 1'b0, 1'b1);
    rnd_mode_i = RNE; tag_i = 4'h7; out_ready_i = 1'b1;
    push_and_wait(lat);
    n_cmp++; if (lat != 2) begin n_mis++; $display("FAIL acc latency: got %0d want 2", lat); end
    acc_clear_i = 1'b1; step(); acc_clear_i = 1'b0;
    n_cmp++; if (acc_inexact_o !== 1'b1) begin n_mis++; $display("FAIL acc set-beats-clear: got %b want 1", acc_inexact_o); end
    acc_clear_i = 1'b1; step(); acc_clear_i = 1'b0;
    n_cmp++; if (acc_inexact_o !== 1'b0) begin n_mis++; $display("FAIL acc clear1: got %b want 0", acc_inexact_o); end
    park_lanes();
    set_lane(0, 8'h33, 1'b1, 2'b11, 1'b1, 1'b0);
    rnd_mode_i = RNE; tag_i = 4'hB;
    push_and_wait(lat);
    n_cmp++; if (lat != 2) begin n_mis++; $display("FAIL masked latency: got %0d want 2", lat); end
    n_cmp++; if ({abs_rounded_o, sign_o, inexact_o, exact_zero_o, carry_out_o} !== '0) begin
      n_mis++; $display("FAIL masked lanes: got abs=%h sign=%b inexact=%b ez=%b co=%b want 0",
                        abs_rounded_o, sign_o, inexact_o, exact_zero_o, carry_out_o); end
    step();
    n_cmp++; if (acc_inexact_o !== 1'b0) begin n_mis++; $display("FAIL masked acc: got %b want 0", acc_inexact_o); end
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    acc_clear_i = 1'b0; tag_i = '0; rnd_mode_i = RNE;
    abs_value_i = '0; sign_i = '0; round_sticky_bits_i = '0;
    effective_subtraction_i = '0; lane_mask_i = '0;
    test_reset();
    test_rounding_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_accumulator();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
